conv_row3_adr_sequencer: RTL and testbench

CONV_ROW3_ADR_SEQUENCER -- requirements
Module: conv_row3_adr_sequencer

---
 rtl/conv_row3_adr_sequencer.sv | 201 ++++++++++++++++++++
 tb/tb_conv_row3_adr_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_row3_adr_sequencer.sv
// -----------------------------------------------------------------------------
// conv_row3_adr_sequencer
//
// Purpose:
//   Walks the input-buffer coordinates needed to compute one tile of a 3-row
//   convolution. For each group of 3 output rows, each kernel row ky and each
//   packed input-feature word, it issues one coordinate set per cycle. The
//   loop order is if_start innermost, then ky, then group.
//
// Parameters:
//   ifs_in_row_2pow : log2 of input features packed per buffer word
//   max_groups      : upper bound on row groups per tile (sizes group counter)
//
// Ports:
//   clk                : clock, all logic on posedge
//   reset              : synchronous active-high reset
//   start              : one-cycle request to begin a sweep (ignored when busy)
//   stall              : back-pressure; holds the sequence while high
//   s                  : conv stride (1 or 2)
//   k                  : kernel height
//   nif_in_2pow        : log2 of input features
//   groups             : number of 3-output-row groups in the tile
//   row_start_idx_cfg  : tile row start, latched and forwarded
//   busy               : high from start acceptance until done
//   done               : one-cycle pulse at sweep completion
//   valid_adr          : a coordinate set is issued this cycle
//   ky                 : current kernel row
//   iy_start           : first input row of current group (3*s*g)
//   if_start           : 1-based input-feature word index
//   row_base_in_3s     : group base in 3-row units (s*g)
//   row_start_idx      : latched row_start_idx_cfg
// -----------------------------------------------------------------------------
module conv_row3_adr_sequencer #(
    parameter int ifs_in_row_2pow = 1,
    parameter int max_groups      = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stall,
    input  logic [3:0]  s,
    input  logic [15:0] k,
    input  logic [3:0]  nif_in_2pow,
    input  logic [15:0] groups,
    input  logic [15:0] row_start_idx_cfg,
    output logic        busy,
    output logic        done,
    output logic        valid_adr,
    output logic [15:0] ky,
    output logic [15:0] iy_start,
    output logic [15:0] if_start,
    output logic [15:0] row_base_in_3s,
    output logic [15:0] row_start_idx
);

    localparam int             G_W   = (max_groups > 1) ? $clog2(max_groups) : 1;
    localparam logic [G_W-1:0] G_ONE = {{(G_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]     IFS4  = 4'(ifs_in_row_2pow);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    state_t          r_state;

    logic            r_busy;
    logic            r_done;
    logic            r_valid;
    logic [15:0]     r_ky;
    logic [15:0]     r_iy;
    logic [15:0]     r_if;
    logic [15:0]     r_rb;
    logic [15:0]     r_rsi;
    logic [G_W-1:0]  r_g;

    // Latched sweep configuration
    logic [15:0]     r_k;
    logic [15:0]     r_groups;
    logic [15:0]     r_nif_words;
    logic [15:0]     r_step1;
    logic [15:0]     r_step3;

    logic [15:0]     w_nif_words;
    logic [15:0]     w_s_ext;
    logic [15:0]     w_s3;
    logic            w_accept;
    logic            w_if_wrap;
    logic            w_ky_wrap;
    logic            w_last;

    // Per-group steps are precomputed once at start so the running
    // coordinates only ever need an add.
    assign w_nif_words = 16'd1 << (nif_in_2pow - IFS4);
    assign w_s_ext     = {12'd0, s};
    assign w_s3        = (w_s_ext << 1) + w_s_ext;
    assign w_accept    = (r_state == IDLE) && start;

    assign w_if_wrap   = (r_if == r_nif_words);
    assign w_ky_wrap   = (r_ky == (r_k - 16'd1));
    assign w_last      = w_if_wrap && w_ky_wrap && (16'(r_g) == (r_groups - 16'd1));

    // Configuration capture: data only, no reset needed; it is only consumed
    // while RUN, which can only be entered through an accepted start.
    always_ff @(posedge clk) begin
        if (!reset && w_accept) begin
            r_k         <= k;
            r_groups    <= groups;
            r_nif_words <= w_nif_words;
            r_step1     <= w_s_ext;
            r_step3     <= w_s3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_valid <= 1'b0;
            r_ky    <= 16'd0;
            r_iy    <= 16'd0;
            r_if    <= 16'd0;
            r_rb    <= 16'd0;
            r_rsi   <= 16'd0;
            r_g     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done  <= 1'b0;
                    r_valid <= 1'b0;
                    if (start) begin
                        r_busy <= 1'b1;
                        r_rsi  <= row_start_idx_cfg;
                        if ((k == 16'd0) || (groups == 16'd0)) begin
                            // Empty sweep: nothing to issue, just signal done.
                            r_state <= FIN;
                            r_done  <= 1'b1;
                        end else begin
                            // First tuple goes out directly off the accept edge.
                            r_state <= RUN;
                            r_valid <= 1'b1;
                            r_ky    <= 16'd0;
                            r_iy    <= 16'd0;
                            r_if    <= 16'd1;
                            r_rb    <= 16'd0;
                            r_g     <= '0;
                        end
                    end
                end

                RUN: begin
                    if (stall) begin
                        // Hold the last issued tuple; it advances once stall drops.
                        r_valid <= 1'b0;
                    end else if (w_last) begin
                        r_valid <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= FIN;
                    end else begin
                        r_valid <= 1'b1;
                        if (w_if_wrap) begin
                            r_if <= 16'd1;
                            if (w_ky_wrap) begin
                                r_ky <= 16'd0;
                                r_g  <= r_g + G_ONE;
                                r_iy <= r_iy + r_step3;
                                r_rb <= r_rb + r_step1;
                            end else begin
                                r_ky <= r_ky + 16'd1;
                            end
                        end else begin
                            r_if <= r_if + 16'd1;
                        end
                    end
                end

                FIN: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy           = r_busy;
    assign done           = r_done;
    assign valid_adr      = r_valid;
    assign ky             = r_ky;
    assign iy_start       = r_iy;
    assign if_start       = r_if;
    assign row_base_in_3s = r_rb;
    assign row_start_idx  = r_rsi;

endmodule

// File: tb/tb_conv_row3_adr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_conv_row3_adr_sequencer
//
// Purpose:
//   Self-checking bench for conv_row3_adr_sequencer. A cycle table covers the
//   stalled 12-issue sweep; hand-written sequences cover the unstalled sweep,
//   stride 2, empty sweeps, reset mid-run and a start while busy.
//   Expected values come from hand tables or from nested reference loops.
// -----------------------------------------------------------------------------
module tb_conv_row3_adr_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        stall;
    logic [3:0]  s;
    logic [15:0] k;
    logic [3:0]  nif_in_2pow;
    logic [15:0] groups;
    logic [15:0] row_start_idx_cfg;
    logic        busy;
    logic        done;
    logic        valid_adr;
    logic [15:0] ky;
    logic [15:0] iy_start;
    logic [15:0] if_start;
    logic [15:0] row_base_in_3s;
    logic [15:0] row_start_idx;

    int n_tests = 0;
    int n_fail  = 0;

    conv_row3_adr_sequencer #(
        .ifs_in_row_2pow (1),
        .max_groups      (1024)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .stall             (stall),
        .s                 (s),
        .k                 (k),
        .nif_in_2pow       (nif_in_2pow),
        .groups            (groups),
        .row_start_idx_cfg (row_start_idx_cfg),
        .busy              (busy),
        .done              (done),
        .valid_adr         (valid_adr),
        .ky                (ky),
        .iy_start          (iy_start),
        .if_start          (if_start),
        .row_base_in_3s    (row_base_in_3s),
        .row_start_idx     (row_start_idx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        stall;
        logic [66:0] exp;
    } vec_t;

    vec_t tbl[16];

    function automatic logic [66:0] pk(input logic b, input logic d, input logic v,
                                       input logic [15:0] eky, input logic [15:0] eiy,
                                       input logic [15:0] eif, input logic [15:0] erb);
        return {b, d, v, eky, eiy, eif, erb};
    endfunction

    function automatic logic [66:0] outs();
        return {busy, done, valid_adr, ky, iy_start, if_start, row_base_in_3s};
    endfunction

    task automatic check(input string name, input logic [82:0] act, input logic [82:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [3:0] ts, input logic [15:0] tk, input logic [3:0] tn,
                           input logic [15:0] tg, input logic [15:0] trs);
        s = ts; k = tk; nif_in_2pow = tn; groups = tg; row_start_idx_cfg = trs;
    endtask

    // Full unstalled sweep against a nested-loop reference. If restart_at >= 0,
    // a second start with a different config is pulsed before that issue.
    task automatic run_seq(input string name, input logic [3:0] ts, input logic [15:0] tk,
                           input logic [3:0] tn, input logic [15:0] tg, input logic [15:0] trs,
                           input int restart_at);
        logic [63:0] q[$];
        logic [63:0] last;
        int nw;
        nw = 1 << (int'(tn) - 1);
        for (int g = 0; g < int'(tg); g++)
            for (int y = 0; y < int'(tk); y++)
                for (int f = 1; f <= nw; f++)
                    q.push_back({16'(y), 16'(3 * int'(ts) * g), 16'(f), 16'(int'(ts) * g)});
        set_cfg(ts, tk, tn, tg, trs);
        start = 1'b1;
        for (int i = 0; i < q.size(); i++) begin
            if (i == restart_at) begin
                start = 1'b1;
                set_cfg(4'd2, 16'd1, 4'd1, 16'd1, 16'h7777);
            end
            step();
            start = 1'b0;
            check({name, "_issue"}, {16'd0, outs()}, {16'd0, 3'b101, q[i]});
        end
        last = q[q.size() - 1];
        check({name, "_rsi"}, {67'd0, row_start_idx}, {67'd0, trs});
        step();
        check({name, "_fin"}, {16'd0, outs()}, {16'd0, 3'b110, last});
        step();
        check({name, "_idle"}, {16'd0, outs()}, {16'd0, 3'b000, last});
        step();
        check({name, "_idle_hold"}, {16'd0, outs()}, {16'd0, 3'b000, last});
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        set_cfg(4'd1, 16'd3, 4'd2, 16'd2, 16'h0055);

        // Stalled sweep: s=1,k=3,nif_words=2,groups=2, stall for 2 cycles after issue 5.
        tbl[0]  = '{1'b1, 1'b0, pk(1, 0, 1, 0, 0, 1, 0)};
        tbl[1]  = '{1'b0, 1'b0, pk(1, 0, 1, 0, 0, 2, 0)};
        tbl[2]  = '{1'b0, 1'b0, pk(1, 0, 1, 1, 0, 1, 0)};
        tbl[3]  = '{1'b0, 1'b0, pk(1, 0, 1, 1, 0, 2, 0)};
        tbl[4]  = '{1'b0, 1'b0, pk(1, 0, 1, 2, 0, 1, 0)};
        tbl[5]  = '{1'b0, 1'b1, pk(1, 0, 0, 2, 0, 1, 0)};
        tbl[6]  = '{1'b0, 1'b1, pk(1, 0, 0, 2, 0, 1, 0)};
        tbl[7]  = '{1'b0, 1'b0, pk(1, 0, 1, 2, 0, 2, 0)};
        tbl[8]  = '{1'b0, 1'b0, pk(1, 0, 1, 0, 3, 1, 1)};
        tbl[9]  = '{1'b0, 1'b0, pk(1, 0, 1, 0, 3, 2, 1)};
        tbl[10] = '{1'b0, 1'b0, pk(1, 0, 1, 1, 3, 1, 1)};
        tbl[11] = '{1'b0, 1'b0, pk(1, 0, 1, 1, 3, 2, 1)};
        tbl[12] = '{1'b0, 1'b0, pk(1, 0, 1, 2, 3, 1, 1)};
        tbl[13] = '{1'b0, 1'b0, pk(1, 0, 1, 2, 3, 2, 1)};
        tbl[14] = '{1'b0, 1'b0, pk(1, 1, 0, 2, 3, 2, 1)};
        tbl[15] = '{1'b0, 1'b0, pk(0, 0, 0, 2, 3, 2, 1)};

        // Reset state
        step();
        step();
        check("reset_state", {outs(), row_start_idx}, 83'd0);
        reset = 1'b0;
        step();
        check("idle_after_reset", {outs(), row_start_idx}, 83'd0);

        // Stalled sweep from the table
        for (int i = 0; i < 16; i++) begin
            start = tbl[i].start;
            stall = tbl[i].stall;
            step();
            check($sformatf("stall_tbl[%0d]", i), {16'd0, outs()}, {16'd0, tbl[i].exp});
        end
        start = 1'b0;
        stall = 1'b0;
        check("stall_rsi", {67'd0, row_start_idx}, {67'd0, 16'h0055});

        // Unstalled sweep, s=1
        run_seq("s1k3", 4'd1, 16'd3, 4'd2, 16'd2, 16'h0123, -1);

        // Stride 2, three groups
        run_seq("s2g3", 4'd2, 16'd1, 4'd1, 16'd3, 16'h0042, -1);

        // Empty sweeps: k == 0 and groups == 0
        for (int z = 0; z < 2; z++) begin
            if (z == 0) set_cfg(4'd1, 16'd0, 4'd2, 16'd2, 16'd9);
            else        set_cfg(4'd1, 16'd3, 4'd2, 16'd0, 16'd9);
            start = 1'b1;
            step();
            start = 1'b0;
            check($sformatf("empty%0d_fin", z), {80'd0, busy, done, valid_adr},
                  {80'd0, 3'b110});
            step();
            check($sformatf("empty%0d_idle", z), {80'd0, busy, done, valid_adr},
                  {80'd0, 3'b000});
        end

        // Reset asserted while the 4th issue is on the outputs
        set_cfg(4'd1, 16'd3, 4'd2, 16'd2, 16'h00AA);
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            start = 1'b0;
        end
        check("pre_reset_issue4", {16'd0, outs()}, {16'd0, pk(1, 0, 1, 1, 0, 2, 0)});
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mid_reset_zero", {outs(), row_start_idx}, 83'd0);
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 20; i++) begin
                step();
                seen += int'(done) + int'(valid_adr) + int'(busy);
            end
            check("no_done_after_reset", {51'd0, 32'(seen)}, 83'd0);
        end
        run_seq("after_reset", 4'd1, 16'd3, 4'd2, 16'd2, 16'h00AA, -1);

        // Second start while running is ignored
        run_seq("restart", 4'd1, 16'd3, 4'd2, 16'd2, 16'h0031, 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
